qam_symbol_scheduler: RTL

Sits between the Streamer QAM-block output and the QAM modulator. It paces 4-bit QAM symbols onto the modulator at a register-programmed symbol rate and frames each transmission as a burst: a fixed alternating preamble followed by a programmed number of payload symbols. When the source FIFO runs dry mid-burst, it inserts a defined idle symbol and counts the underrun, so the modulator never sees an irregular symbol clock.

---
 rtl/qam_symbol_scheduler_pkg.sv | 39 +++
 rtl/qam_symbol_scheduler_symbol_tick_gen.sv | 42 ++++
 rtl/qam_symbol_scheduler.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/qam_symbol_scheduler_pkg.sv
// rtl/qam_symbol_scheduler_pkg.sv - shared types and constants for the QAM symbol scheduler
//
// Purpose: scheduler state encoding, fixed preamble/idle symbols and the
// register-map structures that carry scheduler configuration and status.
// Ports: none (package).
package qam_symbol_scheduler_pkg;

  localparam int SCHED_SYMBOL_W = 4;
  localparam int SCHED_DIV_W    = 16;
  localparam int SCHED_LEN_W    = 16;

  // Encoding is visible through the status register, keep values stable.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2
  } SCHED_STATE;

  localparam logic [SCHED_SYMBOL_W-1:0] PRE_A    = 4'h0;
  localparam logic [SCHED_SYMBOL_W-1:0] PRE_B    = 4'hF;
  localparam logic [SCHED_SYMBOL_W-1:0] IDLE_SYM = 4'h5;

  typedef struct packed {
    logic [SCHED_DIV_W-1:0] period;
    logic [SCHED_LEN_W-1:0] burst_len;
    logic                   enable;
    logic                   start;
  } SCHED_CFG;

  typedef struct packed {
    SCHED_CFG sched_cfg;
  } WR_REGISTERS;

  typedef struct packed {
    SCHED_STATE             state;
    logic [SCHED_LEN_W-1:0] underrun_count;
  } RD_REGISTERS;

endpackage

// File: rtl/qam_symbol_scheduler_symbol_tick_gen.sv
// rtl/qam_symbol_scheduler_symbol_tick_gen.sv - symbol-period tick generator
//
// Purpose: holds the symbol period captured at burst start and produces a
// one-cycle tick every P cycles while running, with P clamped to at least 2.
// Ports:
//   ipClk, ipReset   clock, asynchronous active-low reset
//   i_load           capture i_period and restart the count from 0
//   i_run            count enable; low freezes the count
//   i_period         requested clock cycles per symbol
//   o_tick           combinational tick, high when count == P-1 while running
module symbol_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             ipClk,
  input  logic             ipReset,
  input  logic             i_load,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_period,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_period;
  logic [DIV_W-1:0] r_count;
  logic [DIV_W-1:0] w_period_clamped;

  // A period below 2 would make the tick and the count clear collide.
  assign w_period_clamped = (i_period < DIV_W'(2)) ? DIV_W'(2) : i_period;
  assign o_tick = i_run && (r_count == (r_period - DIV_W'(1)));

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      r_period <= DIV_W'(2);
      r_count  <= '0;
    end else if (i_load) begin
      r_period <= w_period_clamped;
      r_count  <= '0;
    end else if (i_run) begin
      r_count <= o_tick ? '0 : (r_count + DIV_W'(1));
    end
  end

endmodule

// File: rtl/qam_symbol_scheduler.sv
// rtl/qam_symbol_scheduler.sv - paced, burst-framed QAM symbol scheduler
//
// Purpose: accepts 4-bit QAM symbols through a one-entry holding register and
// emits them to the modulator at a programmed symbol rate, framed as bursts of
// an alternating preamble followed by a programmed number of payload symbols.
// A dry source during payload is filled with IDLE_SYM and counted.
// Optional build macro QAM_SCHED_SCRAMBLER_EN: XORs payload symbols with an
// x^7+x^6+1 LFSR stream reseeded at every burst start.
// Ports:
//   ipClk, ipReset                  clock, asynchronous active-low reset
//   ipEnable, ipStart               enable (low aborts), burst start request
//   ipSymbolPeriod, ipBurstLen      period and payload length, latched at start
//   ipQAMBlock/Valid, opQAMBlockReady  source symbol handshake
//   opQAMBlock, opQAMBlockValid     modulator symbol and one-cycle strobe
//   opBusy, opState                 status: not idle, current state
//   opUnderrunCount                 saturating idle-fill count for this burst
module qam_symbol_scheduler
  import qam_symbol_scheduler_pkg::*;
#(
  parameter int SYMBOL_W     = 4,
  parameter int DIV_W        = 16,
  parameter int LEN_W        = 16,
  parameter int PREAMBLE_LEN = 8
) (
  input  logic                ipClk,
  input  logic                ipReset,
  input  logic                ipEnable,
  input  logic                ipStart,
  input  logic [DIV_W-1:0]    ipSymbolPeriod,
  input  logic [LEN_W-1:0]    ipBurstLen,
  input  logic [SYMBOL_W-1:0] ipQAMBlock,
  input  logic                ipQAMBlockValid,
  output logic                opQAMBlockReady,
  output logic [SYMBOL_W-1:0] opQAMBlock,
  output logic                opQAMBlockValid,
  output logic                opBusy,
  output logic [1:0]          opState,
  output logic [LEN_W-1:0]    opUnderrunCount
);

  localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);

  SCHED_STATE          r_state;
  logic                r_ready_en;
  logic                r_hold_full;
  logic [SYMBOL_W-1:0] r_hold;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_remaining;
  logic [LEN_W-1:0]    r_underrun;
  logic [PRE_W-1:0]    r_pre_idx;
  logic                r_valid;
  logic [SYMBOL_W-1:0] r_sym;

  logic                w_start;
  logic                w_run;
  logic                w_tick;
  logic                w_xfer;
  logic [SYMBOL_W-1:0] w_payload_sym;
  logic [SYMBOL_W-1:0] w_scr_mask;

  assign w_start = (r_state == IDLE) && ipStart && ipEnable;
  assign w_run   = (r_state != IDLE) && ipEnable;
  // Ready is held low until the first edge after reset so every output
  // reads 0 while reset is asserted.
  assign opQAMBlockReady = r_ready_en && !r_hold_full;
  assign w_xfer  = ipQAMBlockValid && opQAMBlockReady;
  assign w_payload_sym = r_hold_full ? r_hold : SYMBOL_W'(IDLE_SYM);

  symbol_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .ipClk    (ipClk),
    .ipReset  (ipReset),
    .i_load   (w_start),
    .i_run    (w_run),
    .i_period (ipSymbolPeriod),
    .o_tick   (w_tick)
  );

`ifdef QAM_SCHED_SCRAMBLER_EN
  logic [6:0] r_lfsr;
  logic [6:0] w_lfsr_next;

  // One payload symbol consumes SYMBOL_W successive LFSR output bits; the
  // bit shifted out of the MSB lands in symbol bit 0 first.
  always_comb begin
    logic [6:0] v_s;
    v_s        = r_lfsr;
    w_scr_mask = '0;
    for (int i = 0; i < SYMBOL_W; i++) begin
      w_scr_mask[i] = v_s[6];
      v_s           = {v_s[5:0], v_s[6] ^ v_s[5]};
    end
    w_lfsr_next = v_s;
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      r_lfsr <= 7'h7F;
    end else if (w_start) begin
      r_lfsr <= 7'h7F;
    end else if ((r_state == PAYLOAD) && w_tick) begin
      r_lfsr <= w_lfsr_next;
    end
  end
`else
  assign w_scr_mask = '0;
`endif

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      r_state     <= IDLE;
      r_ready_en  <= 1'b0;
      r_hold_full <= 1'b0;
      r_hold      <= '0;
      r_len       <= '0;
      r_remaining <= '0;
      r_underrun  <= '0;
      r_pre_idx   <= '0;
      r_valid     <= 1'b0;
      r_sym       <= '0;
    end else begin
      r_ready_en <= 1'b1;
      r_valid    <= 1'b0;
      r_sym      <= '0;

      // Transfer only happens while empty and consumption only while full,
      // so these two never compete for the same cycle.
      if (w_xfer) begin
        r_hold      <= ipQAMBlock;
        r_hold_full <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_len      <= ipBurstLen;
            r_underrun <= '0;
            r_pre_idx  <= '0;
            r_state    <= PREAMBLE;
          end
        end

        PREAMBLE: begin
          if (!ipEnable) begin
            r_state <= IDLE;
          end else if (w_tick) begin
            r_valid <= 1'b1;
            r_sym   <= r_pre_idx[0] ? SYMBOL_W'(PRE_B) : SYMBOL_W'(PRE_A);
            if (r_pre_idx == PRE_W'(PREAMBLE_LEN - 1)) begin
              if (r_len == '0) begin
                r_state <= IDLE;
              end else begin
                r_remaining <= r_len;
                r_state     <= PAYLOAD;
              end
            end else begin
              r_pre_idx <= r_pre_idx + PRE_W'(1);
            end
          end
        end

        PAYLOAD: begin
          if (!ipEnable) begin
            r_state <= IDLE;
          end else if (w_tick) begin
            r_valid <= 1'b1;
            r_sym   <= w_payload_sym ^ w_scr_mask;
            if (r_hold_full) begin
              r_hold_full <= 1'b0;
            end else if (r_underrun != '1) begin
              r_underrun <= r_underrun + LEN_W'(1);
            end
            r_remaining <= r_remaining - LEN_W'(1);
            if (r_remaining == LEN_W'(1)) begin
              r_state <= IDLE;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign opQAMBlock      = r_sym;
  assign opQAMBlockValid = r_valid;
  assign opBusy          = (r_state != IDLE);
  assign opState         = r_state;
  assign opUnderrunCount = r_underrun;

endmodule
